// File: rtl/morse_capture_fifo.sv
// Morse keyer capture: classifies mark/space durations into dit/dah symbols,
// assembles characters and queues them in a small FIFO for a reader.
module morse_capture_fifo #(
    parameter int MAX_LEN = 5,
    parameter int LEN_W   = 3,
    parameter int TIME_W  = 40,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                start,
    input  logic                signal,
    input  logic [TIME_W-1:0]   dit_time,
    input  logic [TIME_W-1:0]   dah_time,
    input  logic [TIME_W-1:0]   word_time,
    input  logic [TIME_W-1:0]   tol_time,
    input  logic                rd,
    output logic                out_valid,
    output logic [LEN_W-1:0]    out_len,
    output logic [MAX_LEN-1:0]  out_dits_dahs,
    output logic                out_word,
    output logic                full,
    output logic                error,
    output logic                overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = LEN_W + MAX_LEN + 1;
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, MARK, GAP, DISCARD} state_t;

    state_t              state, state_n;
    logic [TIME_W-1:0]   cnt, cnt_n, cnt_inc, char_th, word_th, dit_diff, dah_diff;
    logic [LEN_W-1:0]    len, len_n;
    logic [MAX_LEN-1:0]  syms, syms_n, sym_vec;
    logic                wp, wp_n, push, err_set, dit_ok, dah_ok;

    logic [ENT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic                pop, do_push, ovf_set;
    logic [ENT_W-1:0]    head;

    assign cnt_inc  = (cnt == '1) ? cnt : cnt + TIME_W'(1);
    assign char_th  = (dah_time > tol_time) ? dah_time - tol_time : '0;
    assign word_th  = (word_time > tol_time) ? word_time - tol_time : '0;
    assign dit_diff = (cnt >= dit_time) ? cnt - dit_time : dit_time - cnt;
    assign dah_diff = (cnt >= dah_time) ? cnt - dah_time : dah_time - cnt;
    assign dit_ok   = dit_diff <= tol_time;
    assign dah_ok   = dah_diff <= tol_time;
    // dit wins when both windows overlap, so the appended bit is simply !dit_ok
    assign sym_vec  = {{(MAX_LEN-1){1'b0}}, ~dit_ok};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        syms_n  = syms;
        wp_n    = wp;
        push    = 1'b0;
        err_set = 1'b0;
        if (ce) begin
            case (state)
                IDLE: if (signal) begin
                    state_n = MARK;
                    cnt_n   = TIME_W'(1);
                end
                MARK: begin
                    if (signal) begin
                        cnt_n = cnt_inc;
                    end else if ((dit_ok || dah_ok) && len != MAX_L) begin
                        syms_n  = syms | (sym_vec << len);
                        len_n   = len + LEN_W'(1);
                        state_n = GAP;
                        cnt_n   = TIME_W'(1);
                    end else begin
                        err_set = 1'b1;
                        state_n = DISCARD;
                        cnt_n   = TIME_W'(1);
                        len_n   = '0;
                        syms_n  = '0;
                    end
                end
                GAP: begin
                    if (signal) begin
                        state_n = MARK;
                        cnt_n   = TIME_W'(1);
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt >= char_th && len != '0) begin
                            push   = 1'b1;
                            len_n  = '0;
                            syms_n = '0;
                            wp_n   = 1'b0;
                        end
                        if (cnt >= word_th) begin
                            wp_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    len_n  = '0;
                    syms_n = '0;
                    if (signal) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= char_th) state_n = GAP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            syms  <= '0;
            wp    <= 1'b0;
            error <= 1'b0;
        end else if (start) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            syms  <= '0;
            wp    <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            len   <= len_n;
            syms  <= syms_n;
            wp    <= wp_n;
            error <= error | err_set;
        end
    end

    // A full FIFO still accepts a push when the same edge pops the head.
    assign pop     = rd && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || pop);
    assign ovf_set = push && (count == FULL_CNT) && !pop;

    always_ff @(posedge clk) begin
        if (do_push && !start) mem[wr_ptr] <= {len, syms, wp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !do_push) count <= count - (PTR_W+1)'(1);
            overflow <= overflow | ovf_set;
        end
    end

    assign head          = mem[rd_ptr];
    assign out_valid     = count != '0;
    assign full          = count == FULL_CNT;
    assign out_len       = out_valid ? head[ENT_W-1 -: LEN_W] : '0;
    assign out_dits_dahs = out_valid ? head[MAX_LEN:1] : '0;
    assign out_word      = out_valid ? head[0] : 1'b0;
endmodule

// File: tb/tb_morse_capture_fifo.sv
// Directed bench for morse_capture_fifo at dit=10, dah=30, word=70, tol=5.
module tb_morse_capture_fifo;
    logic        clk, rst_n, ce, start, signal, rd;
    logic [39:0] dit_time, dah_time, word_time, tol_time;
    logic        out_valid, out_word, full, error, overflow;
    logic [2:0]  out_len;
    logic [4:0]  out_dits_dahs;
    int          checks = 0;
    int          errors = 0;

    morse_capture_fifo dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .signal(signal),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
        .tol_time(tol_time), .rd(rd), .out_valid(out_valid), .out_len(out_len),
        .out_dits_dahs(out_dits_dahs), .out_word(out_word), .full(full),
        .error(error), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark(input int n);
        signal = 1'b1;
        repeat (n) tick();
    endtask

    task automatic space(input int n);
        signal = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pop1();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_start();
        signal = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [2:0] l, input logic [4:0] s, input logic w);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".len"},   64'(out_len), 64'(l));
        chk({tag, ".syms"},  64'(out_dits_dahs), 64'(s));
        chk({tag, ".word"},  64'(out_word), 64'(w));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".outs"},
            64'({out_valid, out_len, out_dits_dahs, out_word, full, error, overflow}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; start = 1'b0; signal = 1'b0; rd = 1'b0;
        dit_time = 40'd10; dah_time = 40'd30; word_time = 40'd70; tol_time = 40'd5;
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // "A": dit then dah, entry appears one cycle after the 26th gap tick
        mark(10); space(10); mark(30); space(25);
        chk("a.before", 64'(out_valid), 64'd0);
        space(1);
        chk_head("a", 3'd2, 5'b00010, 1'b0);
        chk("a.err", 64'(error), 64'd0);
        pop1();
        chk("a.popped", 64'({out_valid, out_len, out_dits_dahs}), 64'd0);
        pop1();
        chk("a.rd_empty", 64'(out_valid), 64'd0);

        // bad mark length sets sticky error; next good char still captured
        do_start();
        mark(20); space(40);
        chk("bad.err", 64'(error), 64'd1);
        chk("bad.noentry", 64'(out_valid), 64'd0);
        mark(10); space(30);
        chk_head("bad.e", 3'd1, 5'b00000, 1'b0);
        chk("bad.err_sticky", 64'(error), 64'd1);
        do_start();
        chk("start.clear", 64'({out_valid, error, overflow}), 64'd0);

        // six dits: the sixth overruns MAX_LEN
        repeat (5) begin mark(10); space(10); end
        chk("six.err_before", 64'(error), 64'd0);
        mark(10); space(10);
        chk("six.err", 64'(error), 64'd1);
        space(30);
        chk("six.noentry", 64'(out_valid), 64'd0);

        // five "E" with no reader: fifth is dropped
        do_start();
        repeat (4) begin mark(10); space(30); end
        chk("ovf.full", 64'({full, overflow}), 64'b10);
        mark(10); space(30);
        chk("ovf.set", 64'({full, overflow}), 64'b11);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("ovf.pop%0d", i), 3'd1, 5'b00000, 1'b0);
            pop1();
        end
        chk("ovf.empty", 64'({out_valid, full}), 64'd0);

        // push and pop on the same edge while full
        do_start();
        repeat (4) begin mark(10); space(30); end
        mark(30); space(25);
        rd = 1'b1;
        space(1);
        rd = 1'b0;
        chk("pp.flags", 64'({full, overflow}), 64'b10);
        chk_head("pp.head", 3'd1, 5'b00000, 1'b0);
        pop1(); pop1(); pop1();
        chk_head("pp.t", 3'd1, 5'b00001, 1'b0);
        pop1();
        chk("pp.empty", 64'(out_valid), 64'd0);

        // word gap between "E" and "T"
        do_start();
        mark(10); space(80); mark(30); space(30);
        chk_head("word.e", 3'd1, 5'b00000, 1'b0);
        pop1();
        chk_head("word.t", 3'd1, 5'b00001, 1'b1);

        // reset mid-dah with two entries queued and error set
        do_start();
        mark(20); space(30);
        repeat (2) begin mark(10); space(30); end
        chk("rst.pre", 64'({out_valid, error}), 64'b11);
        mark(15);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.low");
        tick();
        chk_all_zero("rst.held");
        rst_n = 1'b1;
        signal = 1'b0;
        tick();
        chk_all_zero("rst.after");
        space(40);
        chk("rst.nopartial", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/morse_capture_fifo.md
MORSE_CAPTURE_FIFO -- requirements
Module: morse_capture_fifo

Interface
REQ-001 Parameter MAX_LEN, default 5: maximum dits/dahs per character.
REQ-002 Parameter LEN_W, default 3: width of length fields; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 Parameter TIME_W, default 40: width of timing inputs and the unit counter.
REQ-004 Parameter DEPTH, default 4: number of character entries in the output FIFO; SHALL be a power of 2.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ce  in  1  sample enable; state and counter advance only when ce=1.
REQ-008 start  in  1  synchronous clear of capture state, FIFO and sticky flags.
REQ-009 signal  in  1  keyed input; 1 = mark, 0 = space.
REQ-010 dit_time, dah_time, word_time, tol_time  in  TIME_W each  nominal durations in ce ticks.
REQ-011 rd  in  1  pop request for the FIFO head.
REQ-012 out_valid  out  1  FIFO not empty.
REQ-013 out_len  out  LEN_W  head entry length.
REQ-014 out_dits_dahs  out  MAX_LEN  head entry symbols; bit i = symbol i (0 = dit, 1 = dah); unused bits 0.
REQ-015 out_word  out  1  head entry was preceded by a word gap.
REQ-016 full  out  1  FIFO holds DEPTH entries.
REQ-017 error  out  1  sticky: timing or length violation.
REQ-018 overflow  out  1  sticky: entry dropped because the FIFO was full.

Function
REQ-019 The FSM SHALL have states IDLE, MARK, GAP, DISCARD; the counter SHALL saturate at all-ones and never wrap.
REQ-020 IDLE/GAP with ce=1 and signal=1: go to MARK, counter := 1.
REQ-021 MARK with ce=1 and signal=1: counter increments.
REQ-022 MARK with ce=1 and signal=0: classify counter; |cnt-dit_time|<=tol_time -> append 0; else |cnt-dah_time|<=tol_time -> append 1; else set error and go to DISCARD.
REQ-023 Dit SHALL take priority when both windows match.
REQ-024 Symbols SHALL be appended at bit index len; len increments by 1.
REQ-025 An append with len already equal to MAX_LEN SHALL set error and go to DISCARD.
REQ-026 After a successful append, go to GAP with counter := 1.
REQ-027 GAP with signal=0: counter increments; when it reaches dah_time-tol_time and len>0, push {len, symbols, word_pending}, clear len/symbols/word_pending, stay in GAP.
REQ-028 When the GAP counter reaches word_time-tol_time, set word_pending=1 and go to IDLE.
REQ-029 DISCARD SHALL clear len and symbols, ignore marks, and return to GAP semantics once signal has stayed 0 for dah_time-tol_time ticks.
REQ-030 The first entry after start/reset SHALL have out_word=0.
REQ-031 A push SHALL become visible on out_* in the cycle after the push edge.
REQ-032 rd with out_valid=1 SHALL pop on that edge; rd with out_valid=0 SHALL be ignored.
REQ-033 Push when full without a simultaneous pop SHALL drop the entry, set overflow, and leave stored entries unchanged.
REQ-034 Push and pop on the same edge SHALL both take effect, including when full; occupancy is unchanged.
REQ-035 Head fields SHALL read 0 whenever out_valid=0.
REQ-036 Subtractions dah_time-tol_time and word_time-tol_time SHALL clamp at 0.
REQ-037 start=1 SHALL take priority over ce and rd: FSM := IDLE, counter, len, symbols, word_pending := 0, FIFO emptied, error and overflow := 0.

Reset
REQ-038 While rst_n=0 the block SHALL hold: FSM = IDLE; counter, len, symbols, word_pending = 0; FIFO empty; out_valid, out_len, out_dits_dahs, out_word, full, error, overflow = 0.
REQ-039 Reset asserted mid-mark or mid-FIFO-write SHALL leave no partial entry after release.

Verification (dit=10, dah=30, word=70, tol=5, ce=1, defaults)
REQ-040 Mark 10, space 10, mark 30, space 30 -> one entry, out_len=2, out_dits_dahs=5'b00010, out_word=0, valid on the 26th gap tick +1.
REQ-041 Mark 20, space 40 -> error=1, no entry; next correct "E" (mark 10) -> entry len=1, error still 1 until start.
REQ-042 Six dits with 10-tick gaps -> error=1 at the sixth mark end, no entry pushed.
REQ-043 Five "E" characters, no rd -> full=1 after the fourth; fifth dropped, overflow=1; pops return four len=1 entries in order.
REQ-044 "E", 80-tick space, "T" -> second entry out_len=1, out_dits_dahs=5'b00001, out_word=1.
REQ-045 rst_n pulsed low mid-dah with 2 entries queued -> all outputs 0, out_valid=0 after release.
